// File: rtl/move_display_sequencer.sv
// move_display_sequencer
// Queues cube moves (face + turn) in a small circular FIFO and presents them
// one at a time as a face digit and a modifier digit for the move 7-segment
// decoders. Each move is held for DWELL_CYCLES, then the digits blank for
// GAP_CYCLES so repeated identical moves read as separate moves. A one-cycle
// apply_pulse marks the first display cycle of every move.
//
// Timing: a move offered in one cycle is written at that cycle's closing edge
// and popped/shown from the following edge, so it appears two cycles after it
// is offered when the sequencer is idle.

module move_display_sequencer #(
  parameter int DEPTH        = 8,
  parameter int DWELL_CYCLES = 25000000,
  parameter int GAP_CYCLES   = 5000000
) (
  input  logic                     CLOCK_50,
  input  logic                     reset,
  input  logic                     move_valid,
  output logic                     move_ready,
  input  logic [2:0]               move_face,
  input  logic [1:0]               move_turn,
  input  logic                     clear_flags,
  output logic [3:0]               face_code,
  output logic [3:0]               mod_code,
  output logic                     apply_pulse,
  output logic                     busy,
  output logic [$clog2(DEPTH):0]   queue_count,
  output logic                     overflow,
  output logic                     bad_move
);

  localparam int AW   = $clog2(DEPTH);
  localparam int CW   = AW + 1;
  localparam int MAXC = (DWELL_CYCLES > GAP_CYCLES) ? DWELL_CYCLES : GAP_CYCLES;
  localparam int TW   = $clog2(MAXC + 1);

  localparam bit            HAS_GAP    = (GAP_CYCLES > 0);
  localparam logic [TW-1:0] DWELL_LOAD = TW'(DWELL_CYCLES - 1);
  localparam logic [TW-1:0] GAP_LOAD   = TW'(HAS_GAP ? (GAP_CYCLES - 1) : 0);
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);
  localparam logic [3:0]    BLANK      = 4'hF;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SHOW = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

  // Queue storage: {face[2:0], turn[1:0]}
  logic [4:0]    r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          r_full;

  // Display state
  state_t        r_state;
  logic [TW-1:0] r_timer;
  logic [3:0]    r_face;
  logic [3:0]    r_mod;
  logic          r_apply;
  logic          r_busy;
  logic          r_overflow;
  logic          r_bad;

  logic          w_legal;
  logic          w_push;
  logic          w_pop;
  logic          w_not_empty;
  logic          w_timer_done;
  logic [CW-1:0] w_count_next;
  logic [4:0]    w_head;
  logic [3:0]    w_head_face;
  logic [3:0]    w_head_mod;

  // Modifier digit: B = clockwise, C = counter-clockwise, D = double
  function automatic logic [3:0] turn_to_mod(input logic [1:0] turn);
    logic [3:0] code;
    case (turn)
      2'd0:    code = 4'hB;
      2'd1:    code = 4'hC;
      2'd2:    code = 4'hD;
      default: code = BLANK;
    endcase
    return code;
  endfunction

  assign w_legal      = (move_face <= 3'd5) && (move_turn != 2'd3);
  // Ready comes from the registered full flag only; a same-cycle pop never
  // opens a slot early.
  assign w_push       = move_valid && !r_full && w_legal;
  assign w_not_empty  = (r_count != '0);
  assign w_timer_done = (r_timer == '0);
  assign w_head       = r_mem[r_rd_ptr];
  assign w_head_face  = {1'b0, w_head[4:2]};
  assign w_head_mod   = turn_to_mod(w_head[1:0]);

  // Pop whenever the display is ready for a new move and one is waiting
  always_comb begin
    w_pop = 1'b0;
    if (w_not_empty) begin
      case (r_state)
        ST_IDLE: w_pop = 1'b1;
        ST_SHOW: w_pop = w_timer_done && !HAS_GAP;
        ST_GAP:  w_pop = w_timer_done;
        default: w_pop = 1'b0;
      endcase
    end
  end

  // Occupancy after this edge; push and pop together cancel out
  always_comb begin
    w_count_next = r_count;
    case ({w_push, w_pop})
      2'b10:   w_count_next = r_count + CW'(1);
      2'b01:   w_count_next = r_count - CW'(1);
      default: w_count_next = r_count;
    endcase
  end

  // Queue storage write; stale contents are harmless once pointers reset
  always_ff @(posedge CLOCK_50) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= {move_face, move_turn};
    end
  end

  // Queue pointers and occupancy; pointers wrap naturally (DEPTH is 2^n)
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_full   <= 1'b0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      r_count <= w_count_next;
      r_full  <= (w_count_next == FULL_COUNT);
    end
  end

  // Display FSM: IDLE -> SHOW (dwell) -> GAP (blank) -> SHOW/IDLE
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_timer <= '0;
      r_face  <= BLANK;
      r_mod   <= BLANK;
      r_apply <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_apply <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_pop) begin
            r_state <= ST_SHOW;
            r_timer <= DWELL_LOAD;
            r_face  <= w_head_face;
            r_mod   <= w_head_mod;
            r_apply <= 1'b1;
            r_busy  <= 1'b1;
          end else begin
            r_face  <= BLANK;
            r_mod   <= BLANK;
            r_busy  <= (w_count_next != '0);
          end
        end
        ST_SHOW: begin
          if (!w_timer_done) begin
            r_timer <= r_timer - TW'(1);
            r_busy  <= 1'b1;
          end else if (HAS_GAP) begin
            r_state <= ST_GAP;
            r_timer <= GAP_LOAD;
            r_face  <= BLANK;
            r_mod   <= BLANK;
            r_busy  <= 1'b1;
          end else if (w_pop) begin
            // Back-to-back moves with no blank; still re-announce the move
            r_timer <= DWELL_LOAD;
            r_face  <= w_head_face;
            r_mod   <= w_head_mod;
            r_apply <= 1'b1;
            r_busy  <= 1'b1;
          end else begin
            r_state <= ST_IDLE;
            r_face  <= BLANK;
            r_mod   <= BLANK;
            r_busy  <= (w_count_next != '0);
          end
        end
        ST_GAP: begin
          if (!w_timer_done) begin
            r_timer <= r_timer - TW'(1);
            r_busy  <= 1'b1;
          end else if (w_pop) begin
            r_state <= ST_SHOW;
            r_timer <= DWELL_LOAD;
            r_face  <= w_head_face;
            r_mod   <= w_head_mod;
            r_apply <= 1'b1;
            r_busy  <= 1'b1;
          end else begin
            r_state <= ST_IDLE;
            r_face  <= BLANK;
            r_mod   <= BLANK;
            r_busy  <= (w_count_next != '0);
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_timer <= '0;
          r_face  <= BLANK;
          r_mod   <= BLANK;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  // Sticky error flags; a new event in the same cycle beats clear_flags
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      r_overflow <= 1'b0;
      r_bad      <= 1'b0;
    end else begin
      if (move_valid && r_full) begin
        r_overflow <= 1'b1;
      end else if (clear_flags) begin
        r_overflow <= 1'b0;
      end
      if (move_valid && !w_legal) begin
        r_bad <= 1'b1;
      end else if (clear_flags) begin
        r_bad <= 1'b0;
      end
    end
  end

  assign move_ready  = !r_full;
  assign face_code   = r_face;
  assign mod_code    = r_mod;
  assign apply_pulse = r_apply;
  assign busy        = r_busy;
  assign queue_count = r_count;
  assign overflow    = r_overflow;
  assign bad_move    = r_bad;

endmodule
